sfq_nott_array: RTL



---
 rtl/sfq_nott_array.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sfq_nott_array.sv
// WIDTH-channel cycle-based model of the RSFQ clocked inverter (NOTT) with timing monitors.
// Optional feature: define NOTT_VIOL_COUNT_EN to build the saturating violation event counter.
module sfq_nott_array #(
  parameter int WIDTH       = 4,
  parameter int DELAY       = 3,
  parameter int CT_A_CLK    = 2,
  parameter int CT_CLK_A    = 7,
  parameter int CT_CLK_CLK  = 8,
  parameter int INIT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             sfq_clk,
  input  logic             viol_clr,
  output logic [WIDTH-1:0] q,
  output logic             ready,
  output logic [WIDTH-1:0] viol,
  output logic [15:0]      viol_cnt
);

  localparam int IW = $clog2(INIT_CYCLES + 2);

  typedef enum logic {ARMED = 1'b0, LOADED = 1'b1} state_t;

  state_t           state      [WIDTH];
  state_t           state_next [WIDTH];
  logic [WIDTH-1:0] a_prev;
  logic             clk_prev;
  logic [IW-1:0]    init_cnt;
  logic [7:0]       age_a      [WIDTH];
  logic [7:0]       age_clk;
  logic [WIDTH-1:0] dline      [DELAY];
  logic [WIDTH-1:0] a_pulse;
  logic             clk_pulse;
  logic [WIDTH-1:0] emit;
  logic [WIDTH-1:0] new_viol;

  // Pulses are seen during the init window but only acted on once ready.
  assign ready     = (init_cnt == IW'(INIT_CYCLES));
  assign a_pulse   = (a ^ a_prev) & {WIDTH{ready}};
  assign clk_pulse = (sfq_clk ^ clk_prev) & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_prev   <= a;
      clk_prev <= sfq_clk;
      init_cnt <= '0;
    end else begin
      a_prev   <= a;
      clk_prev <= sfq_clk;
      if (!ready) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst) state[i] <= ARMED;
      else     state[i] <= state_next[i];
    end
  end

  // Clock is applied before data when both arrive together.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_next[i] = state[i];
      emit[i]       = 1'b0;
      new_viol[i]   = 1'b0;
      if (clk_pulse) begin
        emit[i]       = (state[i] == ARMED);
        state_next[i] = ARMED;
      end
      if (a_pulse[i]) state_next[i] = LOADED;
      new_viol[i] = (clk_pulse && (age_a[i] < 8'(CT_A_CLK)))
                 || (clk_pulse && a_pulse[i])
                 || (a_pulse[i] && (state[i] == LOADED))
                 || ((state[i] == ARMED) && a_pulse[i] && (age_clk < 8'(CT_CLK_A)))
                 || ((state[i] == ARMED) && clk_pulse && (age_clk < 8'(CT_CLK_CLK)));
    end
  end

  // Loading 1 on a pulse makes the age read at the next pulse equal the pulse spacing.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_clk <= 8'hFF;
      for (int i = 0; i < WIDTH; i++) age_a[i] <= 8'hFF;
    end else begin
      if (clk_pulse)              age_clk <= 8'd1;
      else if (age_clk != 8'hFF)  age_clk <= age_clk + 8'd1;
      for (int i = 0; i < WIDTH; i++) begin
        if (a_pulse[i])               age_a[i] <= 8'd1;
        else if (age_a[i] != 8'hFF)   age_a[i] <= age_a[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      for (int d = 0; d < DELAY; d++) dline[d] <= '0;
    end else begin
      dline[0] <= emit;
      for (int d = 1; d < DELAY; d++) dline[d] <= dline[d-1];
      q <= q ^ dline[DELAY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) viol <= '0;
    else     viol <= (viol & ~{WIDTH{viol_clr}}) | new_viol;
  end

`ifdef NOTT_VIOL_COUNT_EN
  logic [15:0] cnt_reg;
  logic [15:0] n_viol;
  logic [16:0] cnt_sum;

  always_comb begin
    n_viol = '0;
    for (int i = 0; i < WIDTH; i++) n_viol = n_viol + 16'(new_viol[i]);
    cnt_sum = {1'b0, cnt_reg} + {1'b0, n_viol};
  end

  always_ff @(posedge clk) begin
    if (rst)             cnt_reg <= '0;
    else if (cnt_sum[16]) cnt_reg <= 16'hFFFF;
    else                 cnt_reg <= cnt_sum[15:0];
  end

  assign viol_cnt = cnt_reg;
`else
  assign viol_cnt = '0;
`endif

endmodule
